// File: rtl/q_action_sequencer_if.sv
// q_action_sequencer_if
//   Bundles the signals between the Q action sequencer and its neighbours:
//   the agent scan handshake, the update unit's write port, and the action RAM port.
//   The sequencer connects through 'slave'. The agent, the update unit and
//   the RAM (or a testbench) connect through 'master'.
//
//   Signal groups:
//     agent  : start, state_in -> busy, done, best_act, best_q
//     update : upd_req, upd_addr, upd_data -> upd_ack
//     ram    : ram_en, ram_rd_addr, ram_wr_addr, ram_write_en, ram_data_in
//              <- ram_data_out
//
//   Handshake rules:
//   - upd_req/upd_ack is strict valid/ready. The requester raises upd_req
//     with a stable upd_addr/upd_data and holds all three until it sees
//     upd_ack high at a rising edge. The write commits on exactly that edge.
//     upd_ack is combinational and may depend on upd_addr.
//   - start is a request that is sampled only while the sequencer is idle.
//     A start while busy is dropped, not queued.
//   - done is a one-cycle pulse. best_act and best_q are valid on that
//     cycle and hold their values until the next done.
interface q_action_sequencer_if #(
  parameter int DATA_W  = 16,
  parameter int STATE_W = 4,
  parameter int ACT_W   = 2
);
  localparam int ADDR_W = STATE_W + ACT_W;

  logic               start;
  logic [STATE_W-1:0] state_in;
  logic               busy;
  logic               done;
  logic [ACT_W-1:0]   best_act;
  logic [DATA_W-1:0]  best_q;

  logic               upd_req;
  logic [ADDR_W-1:0]  upd_addr;
  logic [DATA_W-1:0]  upd_data;
  logic               upd_ack;

  logic               ram_en;
  logic [ADDR_W-1:0]  ram_rd_addr;
  logic [ADDR_W-1:0]  ram_wr_addr;
  logic               ram_write_en;
  logic [DATA_W-1:0]  ram_data_in;
  logic [DATA_W-1:0]  ram_data_out;

  modport master (
    output start, state_in, upd_req, upd_addr, upd_data, ram_data_out,
    input  busy, done, best_act, best_q, upd_ack,
           ram_en, ram_rd_addr, ram_wr_addr, ram_write_en, ram_data_in
  );

  modport slave (
    input  start, state_in, upd_req, upd_addr, upd_data, ram_data_out,
    output busy, done, best_act, best_q, upd_ack,
           ram_en, ram_rd_addr, ram_wr_addr, ram_write_en, ram_data_in
  );
endinterface

// File: rtl/q_action_sequencer.sv
// q_action_sequencer
//   Scans the 2**ACT_W Q values of one state in the action RAM and returns
//   the argmax action and the maximum Q value. It also arbitrates the update
//   unit's write port against the scan. A write is held off only while it
//   targets the state that is currently being scanned.
//
//   Ports:
//     clk        : clock. All flops update on the rising edge.
//     rst_n      : asynchronous active-low reset. It aborts a scan without
//                  producing a done pulse.
//     bus        : q_action_sequencer_if.slave. Carries the agent handshake,
//                  the update port and the RAM port.
//     dbg_state  : current FSM state (0 IDLE, 1 RD, 2 LAST, 3 DONE).
//     eps_thresh : exploration threshold. Present only with QSEQ_EXPLORE_EN.
//     explored   : high when best_act was replaced by a random action.
//                  Present only with QSEQ_EXPLORE_EN.
//
//   Optional feature (macro QSEQ_EXPLORE_EN):
//     Adds an 8-bit LFSR for epsilon-greedy exploration. It uses the
//     polynomial x^8+x^6+x^5+x^4+1, has seed 8'hA5, and shifts every clock.
//     When the macro is not defined, the block is purely greedy.
module q_action_sequencer #(
  parameter int DATA_W  = 16,
  parameter int STATE_W = 4,
  parameter int ACT_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  q_action_sequencer_if.slave    bus,
  output logic [1:0]             dbg_state
`ifdef QSEQ_EXPLORE_EN
  ,
  input  logic [7:0]             eps_thresh,
  output logic                   explored
`endif
);
  localparam int ADDR_W = STATE_W + ACT_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    st;
  logic [STATE_W-1:0]        state_q;
  logic [ACT_W-1:0]          cnt;
  logic [ACT_W-1:0]          max_act;
  logic signed [DATA_W-1:0]  max_q;
  logic                      busy_r, done_r, ram_en_r;
  logic [ACT_W-1:0]          best_act_r;
  logic [DATA_W-1:0]         best_q_r;

  // The RAM has one cycle of read latency. The value read now therefore
  // belongs to the address issued one cycle earlier, which is cnt-1. On
  // leaving RD, cnt wraps to 0, so cnt-1 also gives the last action during
  // the LAST cycle.
  logic                      sample_vld, sample_first, sample_gt;
  logic [ACT_W-1:0]          sample_idx;
  logic [ACT_W-1:0]          nxt_act;
  logic signed [DATA_W-1:0]  nxt_q;

  assign sample_vld   = ((st == S_RD) && (cnt != '0)) || (st == S_LAST);
  assign sample_first = (st == S_RD) && (cnt == ACT_W'(1));
  assign sample_idx   = cnt - 1'b1;
  assign sample_gt    = $signed(bus.ram_data_out) > max_q;

  // Only a strictly greater value replaces the running max. On a tie, the
  // lowest action therefore wins.
  always_comb begin
    nxt_act = max_act;
    nxt_q   = max_q;
    if (sample_vld && (sample_first || sample_gt)) begin
      nxt_act = sample_idx;
      nxt_q   = $signed(bus.ram_data_out);
    end
  end

`ifdef QSEQ_EXPLORE_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      state_q    <= '0;
      cnt        <= '0;
      max_act    <= '0;
      max_q      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ram_en_r   <= 1'b0;
      best_act_r <= '0;
      best_q_r   <= '0;
`ifdef QSEQ_EXPLORE_EN
      explored   <= 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_q  <= bus.state_in;
            cnt      <= '0;
            busy_r   <= 1'b1;
            ram_en_r <= 1'b1;
            st       <= S_RD;
          end
        end
        S_RD: begin
          max_act <= nxt_act;
          max_q   <= nxt_q;
          cnt     <= cnt + 1'b1;
          if (cnt == {ACT_W{1'b1}}) begin
            ram_en_r <= 1'b0;
            st       <= S_LAST;
          end
        end
        S_LAST: begin
          max_act  <= nxt_act;
          max_q    <= nxt_q;
          best_q_r <= nxt_q;
          done_r   <= 1'b1;
          st       <= S_DONE;
`ifdef QSEQ_EXPLORE_EN
          if (lfsr < eps_thresh) begin
            best_act_r <= lfsr[ACT_W-1:0];
            explored   <= 1'b1;
          end else begin
            best_act_r <= nxt_act;
            explored   <= 1'b0;
          end
`else
          best_act_r <= nxt_act;
`endif
        end
        S_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          st     <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign dbg_state        = st;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.best_act     = best_act_r;
  assign bus.best_q       = best_q_r;
  assign bus.ram_en       = ram_en_r;
  assign bus.ram_rd_addr  = {state_q, cnt};

  // A write is blocked only while it targets the state being scanned. busy
  // stays high through DONE, so a held-off write is granted in the first
  // IDLE cycle after DONE.
  assign bus.upd_ack      = bus.upd_req &
                            !(busy_r && (bus.upd_addr[ADDR_W-1:ACT_W] == state_q));
  assign bus.ram_write_en = bus.upd_ack;
  assign bus.ram_wr_addr  = bus.upd_addr;
  assign bus.ram_data_in  = bus.upd_data;
endmodule

// File: tb/tb_q_action_sequencer.sv
// tb_q_action_sequencer
//   Directed bench for q_action_sequencer. It uses a behavioural 64x16 action
//   RAM with one cycle of read latency, a table of scan vectors, and
//   hand-written sequences for timing, write arbitration, start while busy,
//   asynchronous reset and (with QSEQ_EXPLORE_EN) exploration.
module tb_q_action_sequencer;
  localparam int DATA_W  = 16;
  localparam int STATE_W = 4;
  localparam int ACT_W   = 2;
  localparam int ADDR_W  = STATE_W + ACT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  q_action_sequencer_if #(.DATA_W(DATA_W), .STATE_W(STATE_W), .ACT_W(ACT_W)) bus ();
  logic [1:0] dbg_state;
`ifdef QSEQ_EXPLORE_EN
  logic [7:0] eps_thresh;
  logic       explored;
`endif

  q_action_sequencer #(.DATA_W(DATA_W), .STATE_W(STATE_W), .ACT_W(ACT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef QSEQ_EXPLORE_EN
    ,
    .eps_thresh(eps_thresh),
    .explored  (explored)
`endif
  );

  // Behavioural action RAM: registered read, write on the acked edge.
  logic [DATA_W-1:0] mem [64];
  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_wr_addr] <= bus.ram_data_in;
    if (bus.ram_en) bus.ram_data_out <= mem[bus.ram_rd_addr];
  end

`ifdef QSEQ_EXPLORE_EN
  // Reference LFSR. m_prev holds the value seen during the previous cycle.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end
`endif

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [ACT_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic write_q(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int w;
    w = 0;
    bus.upd_req = 1'b1; bus.upd_addr = a; bus.upd_data = d;
    #1;
    while (!bus.upd_ack && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 20) begin
      n_vec++; n_fail++;
      $display("FAIL write_ack_timeout: got no ack expected ack for addr %0h", a);
    end
    @(posedge clk); #1;
    bus.upd_req = 1'b0;
  endtask

  // Returns the number of edges between the start edge and the done cycle.
  task automatic run_scan(input logic [STATE_W-1:0] s, output int lat);
    bus.start = 1'b1; bus.state_in = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  typedef struct {
    logic [STATE_W-1:0] st;
    logic [DATA_W-1:0]  q[4];
    logic [ACT_W-1:0]   e_act;
    logic [DATA_W-1:0]  e_q;
  } vec_t;

  typedef struct {
    logic             busy, done, en;
    logic [ADDR_W-1:0] addr;
  } tim_t;

  vec_t vecs[7];
  tim_t tims[7];

  initial begin
    int lat, k, ndone;

    vecs[0] = '{st:4'd3,  q:'{16'h0010,16'h0050,16'h0030,16'h0050}, e_act:2'd1, e_q:16'h0050};
    vecs[1] = '{st:4'd0,  q:'{16'hFFF0,16'hFF00,16'hFFFE,16'h8000}, e_act:2'd2, e_q:16'hFFFE};
    vecs[2] = '{st:4'd9,  q:'{16'h1234,16'h1234,16'h1234,16'h1234}, e_act:2'd0, e_q:16'h1234};
    vecs[3] = '{st:4'd15, q:'{16'h8000,16'h8001,16'h7FFF,16'h0000}, e_act:2'd2, e_q:16'h7FFF};
    vecs[4] = '{st:4'd6,  q:'{16'h0000,16'h0001,16'h0002,16'h0003}, e_act:2'd3, e_q:16'h0003};
    vecs[5] = '{st:4'd10, q:'{16'h7FFF,16'h7FFF,16'h8000,16'h7FFE}, e_act:2'd0, e_q:16'h7FFF};
    vecs[6] = '{st:4'd2,  q:'{16'hFFFF,16'h0000,16'hFFFF,16'h0000}, e_act:2'd1, e_q:16'h0000};

    // Cycles T+1..T+7 after a start of state 5 at edge T.
    tims[0] = '{busy:1, done:0, en:1, addr:6'h14};
    tims[1] = '{busy:1, done:0, en:1, addr:6'h15};
    tims[2] = '{busy:1, done:0, en:1, addr:6'h16};
    tims[3] = '{busy:1, done:0, en:1, addr:6'h17};
    tims[4] = '{busy:1, done:0, en:0, addr:6'h14};
    tims[5] = '{busy:1, done:1, en:0, addr:6'h14};
    tims[6] = '{busy:0, done:0, en:0, addr:6'h14};

    bus.start = 1'b0; bus.state_in = '0;
    bus.upd_req = 1'b0; bus.upd_addr = '0; bus.upd_data = '0;
`ifdef QSEQ_EXPLORE_EN
    eps_thresh = 8'h00;
`endif

    // ---- reset values ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_best_act", bus.best_act, 0);
    check("rst_best_q", bus.best_q, 0);
    check("rst_ram_en", bus.ram_en, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table-driven scans ----
    for (int i = 0; i < 7; i++) begin
      for (int a = 0; a < 4; a++) write_q({vecs[i].st, ACT_W'(a)}, vecs[i].q[a]);
      exp_q.push_back({vecs[i].e_act, vecs[i].e_q});
      run_scan(vecs[i].st, lat);
      check($sformatf("v%0d_latency", i), lat, 5);
      begin
        logic [ACT_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check($sformatf("v%0d_best_act", i), bus.best_act, e[DATA_W+ACT_W-1:DATA_W]);
        check($sformatf("v%0d_best_q", i), bus.best_q, e[DATA_W-1:0]);
      end
`ifdef QSEQ_EXPLORE_EN
      check($sformatf("v%0d_explored", i), explored, 0);
`endif
      @(posedge clk); #1;
    end

    // ---- busy/done/read address timing for state 5 ----
    for (int a = 0; a < 4; a++) write_q({4'd5, ACT_W'(a)}, 16'h0100 * DATA_W'(a + 1));
    write_q(6'h17, 16'h0050);
    bus.start = 1'b1; bus.state_in = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      check($sformatf("t%0d_busy", c + 1), bus.busy, tims[c].busy);
      check($sformatf("t%0d_done", c + 1), bus.done, tims[c].done);
      check($sformatf("t%0d_ram_en", c + 1), bus.ram_en, tims[c].en);
      if (tims[c].en) check($sformatf("t%0d_rd_addr", c + 1), bus.ram_rd_addr, tims[c].addr);
      if (c == 5) begin
        check("t_best_act", bus.best_act, 2);
        check("t_best_q", bus.best_q, 16'h0300);
      end
      @(posedge clk); #1;
    end

    // ---- write arbitration during a scan of state 5 ----
    bus.start = 1'b1; bus.state_in = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.upd_req = 1'b1; bus.upd_addr = 6'h20; bus.upd_data = 16'hBEEF;
    #1;
    check("arb_other_ack", bus.upd_ack, 1);
    @(posedge clk); #1;
    check("arb_other_written", mem[6'h20], 16'hBEEF);
    bus.upd_addr = 6'h15; bus.upd_data = 16'h7000;
    #1;
    k = 2;
    while (!bus.upd_ack && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("arb_held_ack_cycle", k, 7);
    check("arb_held_best_act", bus.best_act, 2);
    check("arb_held_best_q", bus.best_q, 16'h0300);
    @(posedge clk); #1;
    bus.upd_req = 1'b0;
    check("arb_held_written", mem[6'h15], 16'h7000);
    run_scan(4'd5, lat);
    check("arb_rescan_best_act", bus.best_act, 1);
    check("arb_rescan_best_q", bus.best_q, 16'h7000);
    @(posedge clk); #1;

    // ---- start and write in the same idle cycle ----
    for (int a = 0; a < 4; a++) write_q({4'd7, ACT_W'(a)}, 16'h0010 * DATA_W'(a + 1));
    bus.upd_req = 1'b1; bus.upd_addr = 6'h1D; bus.upd_data = 16'h0500;
    bus.start = 1'b1; bus.state_in = 4'd7;
    #1;
    check("same_cycle_ack", bus.upd_ack, 1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.upd_req = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("same_cycle_latency", lat, 5);
    check("same_cycle_best_act", bus.best_act, 1);
    check("same_cycle_best_q", bus.best_q, 16'h0500);
    @(posedge clk); #1;

    // ---- start while busy is ignored ----
    bus.start = 1'b1; bus.state_in = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.state_in = 4'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      if (bus.done) ndone++;
      @(posedge clk); #1;
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_best_act", bus.best_act, 1);
    check("busy_start_best_q", bus.best_q, 16'h7000);

    // ---- asynchronous reset mid-RD ----
    bus.start = 1'b1; bus.state_in = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_best_q", bus.best_q, 0);
    check("arst_best_act", bus.best_act, 0);
    check("arst_ram_en", bus.ram_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done) ndone++;
      @(posedge clk); #1;
    end
    check("arst_no_done", ndone, 0);

`ifdef QSEQ_EXPLORE_EN
    // ---- exploration: eps 00 never explores, eps FF explores unless lfsr==FF ----
    eps_thresh = 8'hFF;
    run_scan(4'd3, lat);
    check("explore_explored", explored, (m_prev < 8'hFF) ? 1 : 0);
    check("explore_best_act", bus.best_act, (m_prev < 8'hFF) ? m_prev[ACT_W-1:0] : 2'd1);
    check("explore_best_q", bus.best_q, 16'h0050);
    @(posedge clk); #1;
    eps_thresh = 8'h00;
    run_scan(4'd3, lat);
    check("explore_off_explored", explored, 0);
    check("explore_off_best_act", bus.best_act, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
